spi_xfer_ctrl: RTL
==================

// Module: spi_xfer_ctrl
// PURPOSE
//  Byte-transfer sequencer that drives the simple_spi core over its 8-bit Wishbone slave port.
//  Initialises SPCR/SPER once after reset, then runs one SPI byte exchange per accepted command:
//  write SPDR, wait for SPIF, clear SPIF, read SPDR, return the RX byte.
//  Sits between a byte-stream client (valid/ready) and the SPI core; it is the only Wishbone master on that core.
// PARAMETERS
//  CLK_DIV    4'h0    {ESPR,SPR} divider code written to SPER[1:0]/SPCR[1:0]
//  CPOL       1'b0    SPCR.CPOL value
//  CPHA       1'b0    SPCR.CPHA value
//  TIMEOUT    4096    max cycles waiting for SPIF (or one ack) before error; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk_i      in   1  clock
//  rst_i      in   1  asynchronous active-high reset
//  cmd_valid  in   1  TX byte offered
//  cmd_ready  out  1  TX byte accepted when valid&ready
//  cmd_data   in   8  TX byte
//  rsp_valid  out  1  RX byte available
//  rsp_ready  in   1  RX byte consumed when valid&ready
//  rsp_data   out  8  RX byte
//  busy       out  1  high from init start until IDLE, and while a transfer is in flight
//  err        out  1  sticky timeout flag; cleared only by reset
//  wb_cyc_o   out  1  Wishbone cycle
//  wb_stb_o   out  1  Wishbone strobe (always == wb_cyc_o)
//  wb_adr_o   out  2  register address: 0 SPCR, 1 SPSR, 2 SPDR, 3 SPER
//  wb_we_o    out  1  write enable
//  wb_dat_o   out  8  write data
//  wb_dat_i   in   8  read data
//  wb_ack_i   in   1  transfer acknowledge
//  wb_inta_i  in   1  core interrupt (used only with SPI_XFER_IRQ_EN)
// BEHAVIOUR
//  Reset: all outputs 0 (cmd_ready, rsp_valid, rsp_data, err, wb_*); busy=0; FSM -> INIT_OFF.
//  Wishbone access: cyc/stb/adr/we/dat_o registered, held stable until the cycle with wb_ack_i=1; deasserted the
//   next cycle; wb_dat_i captured on ack. No back-to-back strobes (min 1 idle cycle between accesses).
//  FSM: INIT_OFF   write SPCR = {SPIE,1'b0,1'b0,1'b1,CPOL,CPHA,CLK_DIV[1:0]} (SPE=0)
//       INIT_SPER  write SPER = {2'b00,4'b0,CLK_DIV[3:2]} (ICNT=0: SPIF every byte)
//       INIT_ON    write SPCR with SPE=1 -> IDLE
//       IDLE       cmd_ready=1 (only here, and only if rsp_valid=0); on handshake latch byte -> WR_DR
//       WR_DR      write SPDR = byte -> WAIT
//       WAIT       read SPSR repeatedly; SPSR[7]=1 -> CLR_IF
//       CLR_IF     write SPSR = 8'h80 (clears SPIF; WCOL bit written 0) -> RD_DR
//       RD_DR      read SPDR; rsp_data <= wb_dat_i, rsp_valid <= 1 -> IDLE
//  rsp_valid held with rsp_data stable until rsp_ready; the next cmd is not accepted while rsp_valid=1
//   (one outstanding byte max; guarantees core RX FIFO never exceeds one entry).
//  busy = (state != IDLE) | rsp_valid.
//  Timeout: counter resets on entry to each state; if it reaches TIMEOUT in any state (missing ack or SPIF):
//   drop cyc/stb, set err, go to ERR. ERR: cmd_ready=0, rsp_valid=0, only reset exits.
//  Reset mid-transfer: immediate clear of bus signals (cyc/stb drop asynchronously), full re-init sequence;
//   any pending rsp is discarded. Core itself must be reset by the same rst_i.
//  SPSR read value other than bit7 is ignored; WCOL never occurs by construction.
// CONFIGURATION
//  SPI_XFER_IRQ_EN defined: SPIE=1 in SPCR writes; WAIT issues no bus cycles, waits for wb_inta_i=1, then
//   -> CLR_IF (which deasserts inta). Timeout still applies.
//  Undefined: SPIE=0; WAIT polls SPSR as above; wb_inta_i unused.
// STRUCTURE
//  spi_ctrl_pkg: register address localparams (SPCR/SPSR/SPDR/SPER), SPCR/SPSR bit indices, state enum.
//  Sub-module spi_wb_access: single-access Wishbone master engine (start/we/adr/wdata in, done/rdata out, hold
//   until ack); FSM in spi_xfer_ctrl only issues start and waits on done.
// TESTING
//  Reset release, core present -> exactly 3 writes: adr0 8'h10|{CPOL,CPHA,div}, adr3 {6'b0,div[3:2]},
//   adr0 8'h50|...; then cmd_ready=1, busy=0.
//  miso_i tied to mosi_o, cmd 8'hA5 -> bus order W2=A5, R1 (poll until bit7), W1=80, R2; rsp_data=8'hA5.
//  Back-to-back cmds 8'h00,8'hFF,8'h3C with rsp_ready=1 -> three rsps in order, no cmd accepted while rsp_valid.
//  rsp_ready=0 for 50 cycles after rsp 8'h5A -> rsp_valid/rsp_data stable, cmd_ready=0, no bus activity.
//  Slave ack forced 0 (or SPIF never set), TIMEOUT=64 -> err=1 within 66 cycles of strobe/entry, cyc=0, stuck.
//  rst_i pulsed during WAIT -> wb_cyc_o=0 same cycle, rsp discarded, init sequence replays, next cmd 8'hC3 ok.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the simple_spi byte-transfer sequencer:
// register map, control/status bit positions and the sequencer state set.
package spi_ctrl_pkg;

  localparam logic [1:0] ADR_SPCR = 2'd0;
  localparam logic [1:0] ADR_SPSR = 2'd1;
  localparam logic [1:0] ADR_SPDR = 2'd2;
  localparam logic [1:0] ADR_SPER = 2'd3;

  localparam int SPCR_SPIE = 7;
  localparam int SPCR_SPE  = 6;
  localparam int SPCR_MSTR = 4;
  localparam int SPCR_CPOL = 3;
  localparam int SPCR_CPHA = 2;
  localparam int SPSR_SPIF = 7;

  typedef enum logic [3:0] {
    ST_INIT_OFF,
    ST_INIT_SPER,
    ST_INIT_ON,
    ST_IDLE,
    ST_WR_DR,
    ST_WAIT,
    ST_CLR_IF,
    ST_RD_DR,
    ST_ERR
  } state_e;

  // Control register image; master mode is always selected.
  function automatic logic [7:0] spcr_val(input logic spie, input logic spe,
                                          input logic cpol, input logic cpha,
                                          input logic [1:0] spr);
    logic [7:0] v;
    v            = 8'h00;
    v[SPCR_SPIE] = spie;
    v[SPCR_SPE]  = spe;
    v[SPCR_MSTR] = 1'b1;
    v[SPCR_CPOL] = cpol;
    v[SPCR_CPHA] = cpha;
    v[1:0]       = spr;
    return v;
  endfunction

endpackage

// File: rtl/spi_wb_access.sv
// Single-access Wishbone master engine. A start pulse launches one
// registered read or write; the request is held until ack, then dropped,
// and done pulses for one cycle with the captured read data.
module spi_wb_access (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       we_i,
  input  logic [1:0] adr_i,
  input  logic [7:0] wdata_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic [1:0] wb_adr_o,
  output logic       wb_we_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);

  logic       cyc_q, cyc_d;
  logic       done_q, done_d;
  logic       we_q, we_d;
  logic [1:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;
  logic [7:0] rdata_q, rdata_d;

  // Launch, hold-until-ack and abort decisions for the single outstanding access.
  always_comb begin
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    if (abort_i) begin
      cyc_d = 1'b0;
    end else if (cyc_q) begin
      if (wb_ack_i) begin
        cyc_d   = 1'b0;
        done_d  = 1'b1;
        rdata_d = wb_dat_i;
      end
    end else if (start_i) begin
      cyc_d = 1'b1;
      we_d  = we_i;
      adr_d = adr_i;
      dat_d = wdata_i;
    end
  end

  // Bus request registers; reset drops the cycle asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_q   <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 2'd0;
      dat_q   <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign done_o   = done_q;
  assign rdata_o  = rdata_q;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Byte-transfer sequencer for the simple_spi core: configures the core
// once after reset, then runs one SPI byte exchange per accepted command.
// Build option SPI_XFER_IRQ_EN: wait for the core interrupt instead of
// polling SPSR for SPIF.
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter logic [3:0] CLK_DIV = 4'h0,
  parameter logic       CPOL    = 1'b0,
  parameter logic       CPHA    = 1'b0,
  parameter int         TIMEOUT = 4096
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       err,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic [1:0] wb_adr_o,
  output logic       wb_we_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  input  logic       wb_inta_i
);

  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
`ifdef SPI_XFER_IRQ_EN
  localparam logic SPIE = 1'b1;
`else
  localparam logic SPIE = 1'b0;
`endif
  localparam logic [7:0] SPCR_OFF = spcr_val(SPIE, 1'b0, CPOL, CPHA, CLK_DIV[1:0]);
  localparam logic [7:0] SPCR_ON  = spcr_val(SPIE, 1'b1, CPOL, CPHA, CLK_DIV[1:0]);
  localparam logic [7:0] SPER_VAL = {6'b0, CLK_DIV[3:2]};
  localparam logic [7:0] SPSR_CLR = 8'(1) << SPSR_SPIF;

  state_e        state_q, state_d;
  logic          issued_q, issued_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    tx_q, tx_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          err_q, err_d;
  logic          busy_q;

  logic          acc_need, acc_start, acc_abort, acc_we, acc_done;
  logic [1:0]    acc_adr;
  logic [7:0]    acc_wdat, acc_rdata;
  logic          cmd_ready_w;
  logic          unused_inta;

  assign cmd_ready_w = (state_q == ST_IDLE) && !rsp_valid_q;
  assign unused_inta = wb_inta_i;

  // Sequencer next state, bus request selection and client handshakes.
  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    tx_d        = tx_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    acc_need    = 1'b0;
    acc_start   = 1'b0;
    acc_abort   = 1'b0;
    acc_we      = 1'b0;
    acc_adr     = ADR_SPCR;
    acc_wdat    = 8'h00;
    tmo_d       = tmo_q;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      ST_INIT_OFF: begin
        acc_need = 1'b1; acc_we = 1'b1; acc_adr = ADR_SPCR; acc_wdat = SPCR_OFF;
        if (acc_done) state_d = ST_INIT_SPER;
      end
      ST_INIT_SPER: begin
        acc_need = 1'b1; acc_we = 1'b1; acc_adr = ADR_SPER; acc_wdat = SPER_VAL;
        if (acc_done) state_d = ST_INIT_ON;
      end
      ST_INIT_ON: begin
        acc_need = 1'b1; acc_we = 1'b1; acc_adr = ADR_SPCR; acc_wdat = SPCR_ON;
        if (acc_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_w) begin
          tx_d    = cmd_data;
          state_d = ST_WR_DR;
        end
      end
      ST_WR_DR: begin
        acc_need = 1'b1; acc_we = 1'b1; acc_adr = ADR_SPDR; acc_wdat = tx_q;
        if (acc_done) state_d = ST_WAIT;
      end
      ST_WAIT: begin
`ifdef SPI_XFER_IRQ_EN
        if (wb_inta_i) state_d = ST_CLR_IF;
`else
        acc_need = 1'b1; acc_we = 1'b0; acc_adr = ADR_SPSR;
        if (acc_done) begin
          if (acc_rdata[SPSR_SPIF]) state_d = ST_CLR_IF;
          else                      issued_d = 1'b0;
        end
`endif
      end
      ST_CLR_IF: begin
        acc_need = 1'b1; acc_we = 1'b1; acc_adr = ADR_SPSR; acc_wdat = SPSR_CLR;
        if (acc_done) state_d = ST_RD_DR;
      end
      ST_RD_DR: begin
        acc_need = 1'b1; acc_we = 1'b0; acc_adr = ADR_SPDR;
        if (acc_done) begin
          rsp_data_d  = acc_rdata;
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_ERR: begin
        rsp_valid_d = 1'b0;
      end
      default: state_d = ST_ERR;
    endcase

    // One access per state visit; WAIT re-arms itself for each poll.
    if (acc_need && !issued_q) begin
      acc_start = 1'b1;
      issued_d  = 1'b1;
    end

    // Missing ack or SPIF: give up the bus and park until reset.
    if ((state_q != ST_IDLE) && (state_q != ST_ERR) && (tmo_q == TMO_MAX)) begin
      state_d   = ST_ERR;
      err_d     = 1'b1;
      acc_abort = 1'b1;
      acc_start = 1'b0;
    end

    if (state_d != state_q) begin
      issued_d = 1'b0;
      tmo_d    = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Sequencer state and client-side registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT_OFF;
      issued_q    <= 1'b0;
      tmo_q       <= '0;
      tx_q        <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      tmo_q       <= tmo_d;
      tx_q        <= tx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
      busy_q      <= (state_d != ST_IDLE) || rsp_valid_d;
    end
  end

  spi_wb_access u_acc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (acc_start),
    .abort_i  (acc_abort),
    .we_i     (acc_we),
    .adr_i    (acc_adr),
    .wdata_i  (acc_wdat),
    .done_o   (acc_done),
    .rdata_o  (acc_rdata),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_adr_o (wb_adr_o),
    .wb_we_o  (wb_we_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  assign cmd_ready = cmd_ready_w;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule
